axis_pattern_checker: RTL

AXIS_PATTERN_CHECKER -- requirements
Module: axis_pattern_checker

---
 rtl/nsdp_checker_pkg.sv | 15 +
 rtl/nsdp_sat_counter.sv | 41 ++++
 rtl/axis_pattern_checker.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/nsdp_checker_pkg.sv
// Shared types and default sizes for the stream pattern checker.
package nsdp_checker_pkg;

    // Default stream data width and counter width.
    localparam int DEFAULT_DW = 32;
    localparam int DEFAULT_CW = 32;

    // Run-control states of the checker.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : nsdp_checker_pkg

// File: rtl/nsdp_sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
// The clear input has priority over inc.
module nsdp_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    // Next count: clear, else increment unless already saturated.
    always_comb begin
        // NOTE: every combinational output is given a default first so no
        // path through the block leaves it unassigned (which would infer a latch).
        value_d = value_q;
        if (clear) begin
            value_d = '0;
        end else if (inc && (value_q != {WIDTH{1'b1}})) begin
            value_d = value_q + WIDTH'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state is written with non-blocking assignments so every flop
        // samples its input from before the edge, independent of statement order.
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule : nsdp_sat_counter

// File: rtl/axis_pattern_checker.sv
// Checks an AXI-Stream input against an incrementing pattern that starts at
// a seed value. Counts the words accepted and the mismatches, and records the
// first mismatch of each run. A run ends after a programmed number of words.
module axis_pattern_checker
    import nsdp_checker_pkg::*;
#(
    parameter int DW = DEFAULT_DW,
    parameter int CW = DEFAULT_CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] axis_in_tdata,
    input  logic          axis_in_tvalid,
    output logic          axis_in_tready,
    input  logic          start,
    input  logic [DW-1:0] seed,
    input  logic [CW-1:0] expected_words,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] word_count,
    output logic [CW-1:0] error_count,
    output logic [CW-1:0] first_err_index,
    output logic [DW-1:0] first_err_data,
    output logic [DW-1:0] first_err_expect,
    output logic          error
);

    state_e        state_q,            state_d;
    logic [DW-1:0] expected_q,         expected_d;
    logic [CW-1:0] target_q,           target_d;
    logic [CW-1:0] word_count_q,       word_count_d;
    logic [CW-1:0] first_err_index_q,  first_err_index_d;
    logic [DW-1:0] first_err_data_q,   first_err_data_d;
    logic [DW-1:0] first_err_expect_q, first_err_expect_d;

    logic          err_clear;
    logic          err_inc;
    logic [CW-1:0] err_value;
    logic          handshake;
    logic          mismatch;
    logic [CW-1:0] word_count_inc;

    // A word is taken only while a run is active.
    assign handshake      = axis_in_tvalid && (state_q == RUN);
    assign mismatch       = handshake && (axis_in_tdata != expected_q);
    assign word_count_inc = word_count_q + CW'(1);

    // Next-state and datapath updates for the run-control FSM.
    always_comb begin
        state_d            = state_q;
        expected_d         = expected_q;
        target_d           = target_q;
        word_count_d       = word_count_q;
        first_err_index_d  = first_err_index_q;
        first_err_data_d   = first_err_data_q;
        first_err_expect_d = first_err_expect_q;
        err_clear          = 1'b0;
        err_inc            = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    expected_d         = seed;
                    target_d           = expected_words;
                    word_count_d       = '0;
                    first_err_index_d  = '0;
                    first_err_data_d   = '0;
                    first_err_expect_d = '0;
                    err_clear          = 1'b1;
                    // A zero-length run completes immediately.
                    state_d = (expected_words == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // start is deliberately ignored while a run is in progress.
                if (handshake) begin
                    word_count_d = word_count_inc;
                    expected_d   = expected_q + DW'(1);
                    if (mismatch) begin
                        err_inc = 1'b1;
                        // The error counter is still zero only before the first
                        // mismatch of the run; once nonzero it never returns to
                        // zero (it saturates), so later mismatches leave these alone.
                        if (err_value == '0) begin
                            first_err_index_d  = word_count_q;
                            first_err_data_d   = axis_in_tdata;
                            first_err_expect_d = expected_q;
                        end
                    end
                    // The last word of the run drops tready on the next edge.
                    if (word_count_inc == target_q) begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any run on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q            <= IDLE;
            expected_q         <= '0;
            target_q           <= '0;
            word_count_q       <= '0;
            first_err_index_q  <= '0;
            first_err_data_q   <= '0;
            first_err_expect_q <= '0;
        end else begin
            state_q            <= state_d;
            expected_q         <= expected_d;
            target_q           <= target_d;
            word_count_q       <= word_count_d;
            first_err_index_q  <= first_err_index_d;
            first_err_data_q   <= first_err_data_d;
            first_err_expect_q <= first_err_expect_d;
        end
    end

    nsdp_sat_counter #(
        .WIDTH(CW)
    ) u_err_counter (
        .clk   (clk),
        .reset (reset),
        .clear (err_clear),
        .inc   (err_inc),
        .value (err_value)
    );

    assign axis_in_tready   = (state_q == RUN);
    assign busy             = (state_q == RUN);
    assign done             = (state_q == DONE);
    assign word_count       = word_count_q;
    assign error_count      = err_value;
    assign first_err_index  = first_err_index_q;
    assign first_err_data   = first_err_data_q;
    assign first_err_expect = first_err_expect_q;
    assign error            = (err_value != '0);

endmodule : axis_pattern_checker
